// File: rtl/game_sequencer_pkg.sv
// game_pkg: shared game states and keycodes for the Breakout sequencer
package game_pkg;
   typedef enum logic [2:0] {MENU, SERVE, PLAY, LIFE_LOST, GAME_OVER, WIN} game_state_t;
   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_ENTER = 8'h28;
endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: inputs from keyboard/datapath/VGA and outputs to datapath/HEX
interface game_sequencer_if;
   logic        vs;
   logic [7:0]  keycode;
   logic        block_hit;
   logic        ball_lost;
   logic        blocks_clear;
   logic        frame_tick;
   logic        dp_reset;
   logic        blocks_reload;
   logic        start_menu;
   logic        serve_hold;
   logic        game_over;
   logic        game_won;
   logic [1:0]  lives;
   logic [15:0] curr_score;
   modport master (
      output vs, keycode, block_hit, ball_lost, blocks_clear,
      input  frame_tick, dp_reset, blocks_reload, start_menu, serve_hold,
             game_over, game_won, lives, curr_score
   );
   modport slave (
      input  vs, keycode, block_hit, ball_lost, blocks_clear,
      output frame_tick, dp_reset, blocks_reload, start_menu, serve_hold,
             game_over, game_won, lives, curr_score
   );
endinterface

// File: rtl/game_sequencer_bcd_score_acc.sv
// bcd_score_acc: 4-digit packed BCD accumulator that saturates at 9999
module bcd_score_acc (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic [3:0]  add_i,
   output logic [15:0] score_o
);
   logic [15:0] score_q, score_d, sum;
   logic [4:0]  dig;
   logic [3:0]  carry;
   // ripple the addend through the digits; a carry out of the top digit saturates
   always_comb begin
      sum = '0;
      dig = '0;
      carry = add_i;
      for (int i = 0; i < 4; i++) begin
         dig = {1'b0, score_q[4*i +: 4]} + {1'b0, carry};
         sum[4*i +: 4] = dig > 5'd9 ? 4'(dig - 5'd10) : dig[3:0];
         carry = dig > 5'd9 ? 4'd1 : 4'd0;
      end
      score_d = carry != 4'd0 ? 16'h9999 : sum;
   end
   // clear wins over accumulate
   always_ff @(posedge Clk) begin
      if (Reset || clr_i) score_q <= '0;
      else if (en_i) score_q <= score_d;
   end
   assign score_o = score_q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: Breakout game-flow FSM, lives, score, frame tick and datapath reset pulses
module game_sequencer
   import game_pkg::*;
#(
   parameter int          START_LIVES   = 3,
   parameter int          PAUSE_FRAMES  = 60,
   parameter int          OVER_FRAMES   = 180,
   parameter logic [7:0]  KEY_SERVE     = KEY_SPACE,
   parameter int          PTS_PER_BLOCK = 1
) (
   input logic Clk,
   input logic Reset,
   game_sequencer_if.slave bus
);
   localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
   localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
   game_state_t state_q, state_d;
   logic [1:0]  lives_q, lives_d;
   logic [7:0]  timer_q, timer_d;
   logic        dp_reset_q, dp_reset_d, reload_q, reload_d;
   logic        key_q;
   logic [2:0]  vs_q;
   logic        press, tick, timed, score_clr;
   assign press = (bus.keycode == KEY_SERVE) && !key_q;
   assign tick  = vs_q[2] && !vs_q[1];
   assign timed = state_q inside {LIFE_LOST, GAME_OVER, WIN};
   // vsync is idle-high, so the synchroniser resets to 1 to avoid a spurious tick
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_q       <= 3'b111;
         key_q      <= 1'b0;
         state_q    <= MENU;
         lives_q    <= 2'(START_LIVES);
         timer_q    <= '0;
         dp_reset_q <= 1'b0;
         reload_q   <= 1'b0;
      end else begin
         vs_q       <= {vs_q[1:0], bus.vs};
         key_q      <= bus.keycode == KEY_SERVE;
         state_q    <= state_d;
         lives_q    <= lives_d;
         timer_q    <= timer_d;
         dp_reset_q <= dp_reset_d;
         reload_q   <= reload_d;
      end
   end
   // next state, lives, frame timer and one-shot pulse requests
   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      timer_d    = (timed && tick) ? timer_q + 8'd1 : timer_q;
      dp_reset_d = 1'b0;
      reload_d   = 1'b0;
      score_clr  = 1'b0;
      case (state_q)
         MENU: if (press) begin
            state_d    = SERVE;
            dp_reset_d = 1'b1;
            reload_d   = 1'b1;
            lives_d    = 2'(START_LIVES);
            score_clr  = 1'b1;
         end
         SERVE: if (press) state_d = PLAY;
         PLAY: if (bus.blocks_clear) state_d = WIN;
            else if (bus.ball_lost) begin
               state_d = lives_q <= 2'd1 ? GAME_OVER : LIFE_LOST;
               lives_d = lives_q <= 2'd1 ? 2'd0 : lives_q - 2'd1;
            end
         LIFE_LOST: if (tick && timer_q == PAUSE_LAST) begin
            state_d    = SERVE;
            dp_reset_d = 1'b1;
         end
         GAME_OVER, WIN: if (press || (tick && timer_q == OVER_LAST)) state_d = MENU;
         default: state_d = MENU;
      endcase
      if (state_d != state_q) timer_d = '0;
   end
   bcd_score_acc u_score (
      .Clk     (Clk),
      .Reset   (Reset),
      .en_i    (bus.block_hit && state_q == PLAY),
      .clr_i   (score_clr),
      .add_i   (4'(PTS_PER_BLOCK)),
      .score_o (bus.curr_score)
   );
   assign bus.frame_tick    = tick;
   assign bus.dp_reset      = dp_reset_q;
   assign bus.blocks_reload = reload_q;
   assign bus.start_menu    = state_q == MENU;
   assign bus.serve_hold    = state_q == SERVE || state_q == LIFE_LOST;
   assign bus.game_over     = state_q == GAME_OVER;
   assign bus.game_won      = state_q == WIN;
   assign bus.lives         = lives_q;
endmodule
